uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte-stream requesters (status reporter, loopback echo, debug dump).
- Packet-level round-robin: a requester keeps the transmitter from its first byte until its byte flagged last.
- Drives the uart_tx start/data_in/ready handshake directly, so top level instantiates uart_tx unchanged with this block in front.
- Aborts a stalled packet after a programmable gap so one requester cannot lock the line.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, byte width; must match uart_tx DATA_BITS
GAP_TIMEOUT, 1024, clk cycles a granted requester may leave req_valid low mid-packet before abort (>=2)

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester i has a byte on its slice of req_data
req_data  input  NUM_REQ*DATA_BITS  requester i byte at bits [i*DATA_BITS +: DATA_BITS]
req_last  input  NUM_REQ  byte on requester i is last of its packet
req_ready  output  NUM_REQ  byte accepted from requester i this cycle (combinational)
tx_ready  input  1  uart_tx ready (high = idle)
tx_start  output  1  one-cycle start pulse to uart_tx
tx_data  output  DATA_BITS  byte to uart_tx data_in, stable while tx_start high and until next accept
grant  output  NUM_REQ  one-hot current owner, 0 when none
busy  output  1  high whenever a grant is held
gap_abort  output  1  one-cycle pulse when a packet is aborted by timeout

Behaviour:
- Reset (async, n_reset low): state IDLE, grant=0, busy=0, tx_start=0, tx_data=0, gap_abort=0, rr pointer=NUM_REQ-1, gap counter=0. All outputs except req_ready are registered.
- States: IDLE, SEND, WAIT_BUSY.
- IDLE: if any req_valid, grant the first valid index searching from rr pointer+1 upward with wrap; next cycle state=SEND, grant one-hot, busy=1. No valid: stay.
- SEND: req_ready[g] = tx_ready & req_valid[g] (g = granted index); all other req_ready bits 0, and all bits 0 outside SEND. On accept: next cycle tx_start=1, tx_data=req_data[g], last flag captured, state=WAIT_BUSY.
- WAIT_BUSY: tx_start high exactly one cycle. Stay until tx_ready observed low (uart_tx drops ready the cycle after sampling start). On low: if captured last, then state=IDLE, grant=0, busy=0, rr pointer=g; else state=SEND.
- Back-to-back: minimum 3 cycles between accepts; no byte is issued while tx_ready low.
- Gap timer: counts in SEND while req_valid[g] low; clears on any accept and on leaving SEND. Reaching GAP_TIMEOUT: gap_abort=1 one cycle, state=IDLE, grant released, rr pointer=g. No byte is sent at abort.
- Simultaneous requests in IDLE: rotation guarantees each valid requester granted within NUM_REQ packets.
- req_last on a packet's first byte: single-byte packet, legal.
- Requester dropping req_valid without acceptance is allowed (no hold requirement); it only advances the gap timer.
- Reset mid-byte: outputs return to reset values immediately; a byte already started in uart_tx is not tracked (uart_tx shares n_reset).
- tx_ready high in WAIT_BUSY for more than GAP_TIMEOUT cycles is a uart_tx fault; not handled.

Test Plan:
- Single requester 0 sends 3 bytes 0x54,0x45,0x53 with last on 0x53, uart_tx model with CLKS_PER_BIT=4 -> three tx_start pulses in order, tx_data matches, grant=0001 throughout, released after third byte, busy low.
- Requesters 1 and 2 both valid from reset with 2-byte packets -> grant 1 first (pointer 3 wraps to 0, 0 idle), both bytes of req 1 sent before any of req 2, then req 2; no interleaving.
- All four requesters hold valid for 8 single-byte packets -> grant order 0,1,2,3,0,1,2,3.
- Requester 3 sends one non-last byte then holds valid low, GAP_TIMEOUT=16 -> gap_abort pulse exactly 16 cycles after entering SEND, grant cleared, next pending requester granted.
- tx_ready forced low in SEND with req_valid high -> req_ready stays 0, no tx_start; release tx_ready -> accept within 1 cycle.
- Assert n_reset low during WAIT_BUSY -> tx_start, grant, busy, gap_abort all 0 same cycle; after release, first grant goes to lowest valid index.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx handshake bundle for uart_tx_arbiter.
// master: arbiter side; slave: requesters plus uart_tx side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_ready;
  logic                         tx_start;
  logic [DATA_BITS-1:0]         tx_data;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic                         gap_abort;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_start, tx_data, grant, busy, gap_abort
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_start, tx_data, grant, busy, gap_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among requesters.
// Ports: clk, n_reset (async low), bus (requester + uart_tx handshake).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = 8,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              n_reset,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        pick;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic                 abort_q, abort_d;
  logic                 last_q, last_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CW-1:0]        gap_q, gap_d;
  logic                 any_valid;
  logic                 g_valid;
  logic                 accept;
  logic                 timeout;
  int                   k;

  // Lowest offset from rr+1 wins; iterate high to low so it is written last.
  always_comb begin
    pick = rr_q;
    k = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(rr_q) + 1 + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (bus.req_valid[IW'(k)]) pick = IW'(k);
    end
  end

  assign any_valid = |bus.req_valid;
  assign g_valid   = bus.req_valid[gidx_q];
  assign accept    = (state_q == SEND) && g_valid && bus.tx_ready;
  assign timeout   = (state_q == SEND) && !g_valid
                  && (gap_q == CW'(GAP_TIMEOUT - 1));

  always_comb begin
    bus.req_ready = '0;
    if (state_q == SEND)
      bus.req_ready[gidx_q] = bus.tx_ready & g_valid;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) state_d = SEND;
      end
      SEND: begin
        if (accept)       state_d = WAIT_BUSY;
        else if (timeout) state_d = IDLE;
      end
      WAIT_BUSY: begin
        // uart_tx drops ready the cycle after it samples start
        if (!bus.tx_ready) state_d = last_q ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    last_d  = last_q;
    data_d  = data_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        gap_d = '0;
        if (any_valid) begin
          gidx_d  = pick;
          grant_d = NUM_REQ'(1) << pick;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (accept) begin
          start_d = 1'b1;
          data_d  = bus.req_data[int'(gidx_q) * DATA_BITS +: DATA_BITS];
          last_d  = bus.req_last[gidx_q];
          gap_d   = '0;
        end else if (timeout) begin
          abort_d = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = gidx_q;
          gap_d   = '0;
        end else if (!g_valid) begin
          gap_d = gap_q + CW'(1);
        end
      end
      WAIT_BUSY: begin
        gap_d = '0;
        if (!bus.tx_ready && last_q) begin
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = gidx_q;
        end
      end
      default: begin
        gap_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      gidx_q  <= '0;
      rr_q    <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      gap_q   <= '0;
    end else begin
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      abort_q <= abort_d;
      last_q  <= last_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.tx_start  = start_q;
  assign bus.tx_data   = data_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.gap_abort = abort_q;
endmodule
